// File: rtl/bus_pkg.sv
// Shared types and default sizing for the memory bus controller.
package bus_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/wait_timer.sv
// Wait-cycle counter for memory transactions: clear, count-enable and
// a terminal-count flag raised when the count reaches TIMEOUT.
module wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  assign tc = (count_q == CW'(TIMEOUT));

  // Next count: clear has priority, saturate at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: MAR/MDR registers, read/write handshake with
// memory, wait-cycle timeout and illegal-command detection.
module mem_bus_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              marce,
  input  logic              maroe,
  input  logic              mdrce,
  input  logic              mdroe,
  input  logic              mdrput,
  input  logic              mdrget,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              cmd_err
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              cmd_err_q, cmd_err_d;
  logic              start, tmr_en, tmr_tc;
  logic              rd_ok, wr_ok;

  assign rd_ok = mem_read & ~mem_write & maroe;
  assign wr_ok = mem_write & ~mem_read & maroe & mdroe;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .en (tmr_en),
    .tc (tmr_tc)
  );

  assign busy      = (state_q != ST_IDLE);
  assign mem_req   = busy;
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign bus_out   = mdr_q;
  assign bus_oe    = mdroe & mdrget;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cmd_err   = cmd_err_q;

  // Next-state, register loads and pulse generation.
  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    cmd_err_d = 1'b0;
    start     = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (marce) mar_d = bus_in;
        if (mdrce && mdrput) mdr_d = bus_in;
        if (rd_ok) begin
          state_d = ST_READ;
          start   = 1'b1;
        end else if (wr_ok) begin
          state_d = ST_WRITE;
          start   = 1'b1;
        end else if (mem_read || mem_write) begin
          cmd_err_d = 1'b1;
        end
      end
      ST_READ, ST_WRITE: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (state_q == ST_READ) mdr_d = mem_rdata;
        end else if (tmr_tc) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          if (state_q == ST_READ) mdr_d = '1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, MAR/MDR and status-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cmd_err_q <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
module tb_mem_bus_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] bus_in;
  logic          marce, maroe, mdrce, mdroe, mdrput, mdrget;
  logic          mem_read, mem_write;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy, done, timeout, cmd_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: registers plus "transaction in flight" bookkeeping.
  logic [DW-1:0] m_mar, m_mdr;
  bit            m_in_txn, m_is_write;
  int unsigned   m_waited;
  bit            m_done, m_timeout, m_cmd_err;

  mem_bus_ctrl #(
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_in   (bus_in),
    .marce    (marce),
    .maroe    (maroe),
    .mdrce    (mdrce),
    .mdroe    (mdroe),
    .mdrput   (mdrput),
    .mdrget   (mdrget),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mar = '0; m_mdr = '0;
    m_in_txn = 0; m_is_write = 0; m_waited = 0;
    m_done = 0; m_timeout = 0; m_cmd_err = 0;
  endtask

  // One clock of the transaction-level model, using the inputs applied this cycle.
  task automatic model_step();
    m_done = 0; m_timeout = 0; m_cmd_err = 0;
    if (!m_in_txn) begin
      if (marce) m_mar = bus_in;
      if (mdrce && mdrput) m_mdr = bus_in;
      if (mem_read && !mem_write && maroe) begin
        m_in_txn = 1; m_is_write = 0; m_waited = 0;
      end else if (mem_write && !mem_read && maroe && mdroe) begin
        m_in_txn = 1; m_is_write = 1; m_waited = 0;
      end else if (mem_read || mem_write) begin
        m_cmd_err = 1;
      end
    end else if (mem_ack) begin
      m_in_txn = 0; m_done = 1;
      if (!m_is_write) m_mdr = mem_rdata;
    end else if (m_waited == TO) begin
      m_in_txn = 0; m_timeout = 1;
      if (!m_is_write) m_mdr = 16'hFFFF;
    end else begin
      m_waited++;
    end
  endtask

  task automatic check_all();
    check_eq("busy",      32'(busy),      32'(m_in_txn));
    check_eq("mem_req",   32'(mem_req),   32'(m_in_txn));
    check_eq("mem_we",    32'(mem_we),    32'(m_in_txn && m_is_write));
    check_eq("done",      32'(done),      32'(m_done));
    check_eq("timeout",   32'(timeout),   32'(m_timeout));
    check_eq("cmd_err",   32'(cmd_err),   32'(m_cmd_err));
    check_eq("mem_addr",  32'(mem_addr),  32'(m_mar));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(m_mdr));
    check_eq("bus_out",   32'(bus_out),   32'(m_mdr));
    check_eq("bus_oe",    32'(bus_oe),    32'(mdroe & mdrget));
  endtask

  // Inputs are driven at the falling edge before calling this.
  task automatic do_cycle();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_in = '0; marce = 0; maroe = 0; mdrce = 0; mdroe = 0;
    mdrput = 0; mdrget = 0; mem_read = 0; mem_write = 0;
    mem_rdata = '0; mem_ack = 0;
  endtask

  int unsigned n;
  int unsigned ack_pct;

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_busy",    32'(busy),    0);
    check_eq("rst_mem_req", 32'(mem_req), 0);
    check_eq("rst_bus_out", 32'(bus_out), 0);
    check_eq("rst_addr",    32'(mem_addr), 0);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Read: load MAR, command, ack one cycle later.
    idle_inputs(); marce = 1; bus_in = 16'h0040; do_cycle();
    idle_inputs(); mem_read = 1; maroe = 1; do_cycle();
    idle_inputs(); mem_ack = 1; mem_rdata = 16'hBEEF;
    #1;
    check_eq("rd_req_n1",  32'(mem_req),  1);
    check_eq("rd_addr_n1", 32'(mem_addr), 32'h0040);
    do_cycle();
    idle_inputs();
    #1;
    check_eq("rd_done_n2", 32'(done),    1);
    check_eq("rd_req_n2",  32'(mem_req), 0);
    check_eq("rd_mdr_n2",  32'(bus_out), 32'hBEEF);
    do_cycle();

    // Write with MDR loaded in the same cycle as the command.
    idle_inputs(); mdrce = 1; mdrput = 1; bus_in = 16'h1234;
    mem_write = 1; maroe = 1; mdroe = 1; do_cycle();
    idle_inputs();
    #1;
    check_eq("wr_we",    32'(mem_we),    1);
    check_eq("wr_wdata", 32'(mem_wdata), 32'h1234);
    do_cycle();
    idle_inputs(); mem_ack = 1; do_cycle();
    idle_inputs();
    #1;
    check_eq("wr_done", 32'(done), 1);
    do_cycle();

    // Read that never gets an ack.
    idle_inputs(); mem_read = 1; maroe = 1; do_cycle();
    idle_inputs();
    n = 0;
    while (busy && n < 40) begin
      do_cycle();
      n++;
    end
    check_eq("to_busy_cycles", n, 16);
    #1;
    check_eq("to_pulse",  32'(timeout), 1);
    check_eq("to_mdr",    32'(bus_out), 32'hFFFF);
    check_eq("to_idle",   32'(busy),    0);
    do_cycle();

    // Conflicting commands.
    idle_inputs(); mem_read = 1; mem_write = 1; maroe = 1; mdroe = 1; do_cycle();
    idle_inputs();
    #1;
    check_eq("cerr_pulse", 32'(cmd_err), 1);
    check_eq("cerr_req",   32'(mem_req), 0);
    do_cycle();
    #1;
    check_eq("cerr_clear", 32'(cmd_err), 0);
    check_eq("cerr_req2",  32'(mem_req), 0);

    // MAR must hold while a read is outstanding.
    idle_inputs(); marce = 1; bus_in = 16'h0011; do_cycle();
    idle_inputs(); mem_read = 1; maroe = 1; do_cycle();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); marce = 1; bus_in = 16'h00FF; do_cycle();
      check_eq("hold_addr", 32'(mem_addr), 32'h0011);
    end
    idle_inputs(); marce = 1; bus_in = 16'h00FF; mem_ack = 1; mem_rdata = 16'h5A5A; do_cycle();
    idle_inputs();
    #1;
    check_eq("hold_done",  32'(done),     1);
    check_eq("hold_addr2", 32'(mem_addr), 32'h0011);
    do_cycle();

    // Reset two cycles into a read with the ack still pending.
    idle_inputs(); mem_read = 1; maroe = 1; do_cycle();
    idle_inputs(); do_cycle();
    do_cycle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_req",  32'(mem_req), 0);
    check_eq("arst_busy", 32'(busy),    0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      check_eq("arst_done", 32'(done),    0);
      check_eq("arst_to",   32'(timeout), 0);
      check_eq("arst_mdr",  32'(bus_out), 0);
    end

    // Randomized traffic.
    ack_pct = 50;
    for (int unsigned c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: ack_pct = 0;
          1: ack_pct = 10;
          2: ack_pct = 50;
          default: ack_pct = 90;
        endcase
      end
      bus_in    = 16'($urandom);
      marce     = 1'($urandom_range(0, 1));
      mdrce     = 1'($urandom_range(0, 1));
      mdrput    = 1'($urandom_range(0, 1));
      mdrget    = 1'($urandom_range(0, 1));
      maroe     = ($urandom_range(0, 3) != 0);
      mdroe     = ($urandom_range(0, 3) != 0);
      mem_read  = ($urandom_range(0, 3) == 0);
      mem_write = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
      mem_ack   = ($urandom_range(0, 99) < ack_pct);
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
